dbus_if: RTL and testbench
==========================

Name: dbus_if

Overview:
- Data-bus interface sitting directly downstream of the MEM stage.
- Consumes MEM's memory request (ce/we/addr/sel/data) and launches one registered bus transaction per request toward the data RAM/bus.
- Returns read data to MEM's mem_data_i and raises a stall request to ctrl until the access completes.
- Handles pipeline stall and flush interaction so each MEM-stage instruction produces exactly one bus access.

Parameters:
- DATA_W, 32, width of address and data buses.
- SEL_W, 4, byte-select width (DATA_W/8).
- TIMEOUT_CYCLES, 255, BUSY cycles before bus error (used only with DBUS_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- cpu_ce_i  in  1  MEM-stage chip enable (mem_ce_o).
- cpu_we_i  in  1  MEM-stage write enable.
- cpu_addr_i  in  DATA_W  MEM-stage address, already word-aligned where required.
- cpu_sel_i  in  SEL_W  byte selects.
- cpu_data_i  in  DATA_W  store data.
- cpu_data_o  out  DATA_W  read data returned to MEM (mem_data_i).
- stall_i  in  6  ctrl stall vector; bit 4 = MEM stage held.
- flush_i  in  1  pipeline flush from ctrl.
- stallreq_o  out  1  stall request to ctrl.
- bus_req_o  out  1  bus request, held until ack.
- bus_we_o  out  1  bus write enable.
- bus_addr_o  out  DATA_W  bus address.
- bus_sel_o  out  SEL_W  bus byte selects.
- bus_wdata_o  out  DATA_W  bus write data.
- bus_ack_i  in  1  bus completion, valid only while bus_req_o=1.
- bus_rdata_i  in  DATA_W  read data, valid with bus_ack_i.
- bus_err_o  out  1  one-cycle bus-error pulse (0 unless DBUS_TIMEOUT_EN).

Behaviour:
- Reset (rst=0, async):
  - State = IDLE.
  - All bus_* outputs = 0, cpu_data_o = 0, bus_err_o = 0.
  - drop flag = 0, timeout counter = 0.
- stallreq_o is combinational: 1 when (IDLE & cpu_ce_i & ~flush_i) or BUSY; otherwise 0.
- IDLE:
  - On cpu_ce_i=1 and flush_i=0: register we/addr/sel/wdata onto the bus_* outputs, set bus_req_o=1, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - bus_* outputs are held stable.
  - flush_i=1 sets the drop flag; the transaction is never abandoned mid-bus.
  - On bus_ack_i=1:
    - Clear bus_req_o.
    - If read, capture bus_rdata_i into cpu_data_o; writes leave cpu_data_o unchanged.
    - If drop=1, clear drop and go to IDLE; else go to DONE.
- DONE:
  - stallreq_o=0; cpu_data_o stays valid for MEM.
  - stall_i[4]=1 and flush_i=0: stay in DONE; no reissue.
  - stall_i[4]=0 or flush_i=1: go to IDLE (instruction leaves MEM at this edge).
- Latency:
  - Zero-wait ack (ack in first BUSY cycle) gives 2 stall cycles; instruction spends 3 cycles in MEM.
  - Each bus wait cycle adds 1.
- bus_ack_i in IDLE or DONE is ignored.
- Back-to-back requests: a new request is only sampled in IDLE, so there is a minimum of 1 idle cycle between bus_req_o pulses.
- Reset asserted mid-transaction returns to IDLE immediately and drops bus_req_o; the bus is expected to be reset alongside.

Optional Feature:
- Macro: DBUS_TIMEOUT_EN.
- Defined:
  - 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - Reaching TIMEOUT_CYCLES clears bus_req_o, pulses bus_err_o for 1 cycle and loads cpu_data_o=32'h0.
  - Then goes to DONE, or to IDLE if the drop flag is set.
  - A late ack after timeout is ignored.
- Undefined: no counter; BUSY waits indefinitely; bus_err_o tied 0.

Decomposition:
- define.v additions: DbusStateBus (2 bits), DBUS_IDLE=2'b00, DBUS_BUSY=2'b01, DBUS_DONE=2'b10, StallBus (5:0).
- Reuse existing ZeroWord, ChipEnable, WriteEnable.
- One sub-module: dbus_timeout_cnt (counter plus expiry compare), instantiated only under DBUS_TIMEOUT_EN.
- State machine, request registers and read buffer stay in dbus_if.

Test Plan:
- LW to 0x100 with ack 1 cycle after req (rdata=0xDEADBEEF) -> stallreq_o high exactly 3 cycles, cpu_data_o=0xDEADBEEF in DONE, single req pulse.
- SB to 0x103, sel=4'b0001, wdata=0x55555555, zero-wait ack -> bus_we_o=1, bus_sel_o=0001, bus_addr_o=0x103 stable until ack, cpu_data_o unchanged.
- Read completes while stall_i[4]=1 for 4 cycles -> state holds DONE 4 cycles, stallreq_o=0, no second bus_req_o.
- flush_i pulsed in second BUSY cycle, ack at cycle 5 -> req holds until ack, then IDLE; DONE never entered; next request starts normally.
- rst asserted (async, 0) during BUSY -> bus_req_o=0 and stallreq_o=0 before the next clk edge; after release, LW completes normally.
- DBUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> bus_err_o single pulse after 8 BUSY cycles, cpu_data_o=0, late ack ignored.

Source files
------------

// File: rtl/dbus_if_pkg.sv
// dbus_if_pkg: shared constants and types for the data-bus interface.
//   - DBUS_* state encodings for the dbus_if request FSM
//   - stall_bus_t, the ctrl stall vector, and the index of the MEM-stage bit
//   - enable polarities shared with the rest of the pipeline
//   - mem_held(): true while ctrl holds the MEM stage and no flush is pending
package dbus_if_pkg;

  // FSM state encodings (2-bit state bus)
  localparam int DBUS_STATE_W = 2;
  localparam logic [1:0] DBUS_IDLE = 2'b00;
  localparam logic [1:0] DBUS_BUSY = 2'b01;
  localparam logic [1:0] DBUS_DONE = 2'b10;

  // ctrl stall vector, bit 4 holds the MEM stage
  typedef logic [5:0] stall_bus_t;
  localparam int STALL_MEM_BIT = 4;

  // Enable polarities
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  // Width of the bus-timeout counter
  localparam int DBUS_TIMEOUT_W = 8;

  // The MEM-stage instruction stays put only when held and not flushed.
  function automatic logic mem_held(input stall_bus_t stall, input logic flush);
    return stall[STALL_MEM_BIT] && !flush;
  endfunction

endpackage

// File: rtl/dbus_timeout_cnt.sv
// dbus_timeout_cnt: BUSY-cycle watchdog for dbus_if.
// Only built when DBUS_TIMEOUT_EN is defined.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   clear    in   zero the counter (transaction launch)
//   inc      in   one BUSY cycle passed without ack
//   expired  out  combinational: this BUSY cycle is the LIMIT-th without ack
`ifdef DBUS_TIMEOUT_EN
module dbus_timeout_cnt
  import dbus_if_pkg::*;
#(
  parameter int CNT_W = DBUS_TIMEOUT_W,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // cnt_reg holds the number of ack-less BUSY cycles already elapsed, so the
  // LIMIT-th such cycle is the one where it reads LIMIT-1.
  assign expired = inc && (cnt_reg == CNT_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/dbus_if.sv
// dbus_if: data-bus interface behind the MEM stage.
// Launches exactly one registered bus transaction per MEM-stage request,
// returns read data to MEM and stalls the pipeline until the access ends.
// Optional feature macro: DBUS_TIMEOUT_EN (bus watchdog with bus_err_o pulse).
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cpu_ce_i/we_i/addr_i/sel_i/data_i   request from MEM
//   cpu_data_o               read data back to MEM
//   stall_i, flush_i         ctrl stall vector and flush
//   stallreq_o               stall request to ctrl (combinational)
//   bus_req_o/we_o/addr_o/sel_o/wdata_o registered bus request
//   bus_ack_i, bus_rdata_i   bus completion and read data
//   bus_err_o                one-cycle timeout pulse (0 without DBUS_TIMEOUT_EN)
module dbus_if
  import dbus_if_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int SEL_W          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [DATA_W-1:0] cpu_addr_i,
  input  logic [SEL_W-1:0]  cpu_sel_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  output logic              stallreq_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [DATA_W-1:0] bus_addr_o,
  output logic [SEL_W-1:0]  bus_sel_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              bus_err_o
);

  logic [DBUS_STATE_W-1:0] state_reg;
  logic                    drop_reg;
  logic                    start;
  logic                    busy;
  logic                    drop_now;
  logic                    timeout_hit;

  assign start = (state_reg == DBUS_IDLE) && (cpu_ce_i == CHIP_ENABLE) && !flush_i;
  assign busy  = (state_reg == DBUS_BUSY);

  // A flush arriving in the same cycle as the ack must still discard the
  // result, otherwise the flushed instruction would sit in DONE.
  assign drop_now = drop_reg | flush_i;

  // Gated by rst so the request drops the moment reset is asserted.
  assign stallreq_o = rst & (start | busy);

`ifdef DBUS_TIMEOUT_EN
  logic bus_err_reg;

  dbus_timeout_cnt #(
    .CNT_W (DBUS_TIMEOUT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (start),
    .inc     (busy & ~bus_ack_i),
    .expired (timeout_hit)
  );

  // timeout_hit moves the FSM out of BUSY, so this is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err_reg <= 1'b0;
    end else begin
      bus_err_reg <= timeout_hit;
    end
  end

  assign bus_err_o = bus_err_reg;
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign bus_err_o          = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // Only the MEM-stage bit of the stall vector matters here.
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall_i[5], stall_i[3:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= DBUS_IDLE;
      drop_reg    <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= '0;
      bus_wdata_o <= '0;
      cpu_data_o  <= '0;
    end else begin
      case (state_reg)
        DBUS_IDLE: begin
          if (start) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= cpu_we_i;
            bus_addr_o  <= cpu_addr_i;
            bus_sel_o   <= cpu_sel_i;
            bus_wdata_o <= cpu_data_i;
            drop_reg    <= 1'b0;
            state_reg   <= DBUS_BUSY;
          end
        end

        DBUS_BUSY: begin
          // The bus request is never abandoned: a flush only marks the
          // result for discard once the bus finishes.
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            if (bus_we_o != WRITE_ENABLE) begin
              cpu_data_o <= bus_rdata_i;
            end
            drop_reg  <= 1'b0;
            state_reg <= drop_now ? DBUS_IDLE : DBUS_DONE;
          end else if (timeout_hit) begin
            bus_req_o  <= 1'b0;
            cpu_data_o <= '0;
            drop_reg   <= 1'b0;
            state_reg  <= drop_now ? DBUS_IDLE : DBUS_DONE;
          end else if (flush_i) begin
            drop_reg <= 1'b1;
          end
        end

        DBUS_DONE: begin
          // Hold the result until the instruction leaves MEM.
          if (!mem_held(stall_i, flush_i)) begin
            state_reg <= DBUS_IDLE;
          end
        end

        default: begin
          state_reg <= DBUS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_if.sv
module tb_dbus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        stallreq_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dbus_if #(
    .DATA_W         (32),
    .SEL_W          (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_ce_i    (cpu_ce_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_sel_i   (cpu_sel_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .stallreq_o  (stallreq_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_sel_o   (bus_sel_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_ack_i   (bus_ack_i),
    .bus_rdata_i (bus_rdata_i),
    .bus_err_o   (bus_err_o)
  );

  typedef struct packed {
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        stall4;
    logic        flush;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_sr;
    logic        exp_req;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic ce, input logic we, input logic [31:0] addr,
                              input logic [3:0] sel, input logic [31:0] wdata,
                              input logic stall4, input logic flush, input logic ack,
                              input logic [31:0] rdata, input logic exp_sr,
                              input logic exp_req, input logic exp_we,
                              input logic [31:0] exp_addr, input logic [31:0] exp_data);
    vec_t v;
    v.ce = ce; v.we = we; v.addr = addr; v.sel = sel; v.wdata = wdata;
    v.stall4 = stall4; v.flush = flush; v.ack = ack; v.rdata = rdata;
    v.exp_sr = exp_sr; v.exp_req = exp_req; v.exp_we = exp_we;
    v.exp_addr = exp_addr; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic drive(input logic ce, input logic we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] wdata,
                       input logic stall4, input logic flush, input logic ack,
                       input logic [31:0] rdata);
    cpu_ce_i    = ce;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_sel_i   = sel;
    cpu_data_i  = wdata;
    stall_i     = stall4 ? 6'b011111 : 6'b000000;
    flush_i     = flush;
    bus_ack_i   = ack;
    bus_rdata_i = rdata;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    // Vector script: LW with 1 wait, SB zero-wait, read completing under stall.
    //            ce  we addr          sel    wdata         st fl ak rdata          sr req we exp_addr      exp_data
    vecs[0]  = mk(1, 0, 32'h100, 4'hF, 32'h0,        0, 0, 0, 32'h0,        1, 0, 0, 32'h0,   32'h0);
    vecs[1]  = mk(1, 0, 32'h100, 4'hF, 32'h0,        0, 0, 0, 32'h0,        1, 1, 0, 32'h100, 32'h0);
    vecs[2]  = mk(1, 0, 32'h100, 4'hF, 32'h0,        0, 0, 1, 32'hDEADBEEF, 1, 1, 0, 32'h100, 32'h0);
    vecs[3]  = mk(1, 0, 32'h100, 4'hF, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 32'h100, 32'hDEADBEEF);
    vecs[4]  = mk(0, 0, 32'h0,   4'h0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 32'h100, 32'hDEADBEEF);
    vecs[5]  = mk(1, 1, 32'h103, 4'h1, 32'h55555555, 0, 0, 0, 32'h0,        1, 0, 0, 32'h100, 32'hDEADBEEF);
    vecs[6]  = mk(1, 1, 32'h103, 4'h1, 32'h55555555, 0, 0, 1, 32'h12345678, 1, 1, 1, 32'h103, 32'hDEADBEEF);
    vecs[7]  = mk(1, 1, 32'h103, 4'h1, 32'h55555555, 0, 0, 0, 32'h0,        0, 0, 1, 32'h103, 32'hDEADBEEF);
    vecs[8]  = mk(0, 0, 32'h0,   4'h0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 1, 32'h103, 32'hDEADBEEF);
    vecs[9]  = mk(1, 0, 32'h200, 4'hF, 32'h0,        0, 0, 0, 32'h0,        1, 0, 1, 32'h103, 32'hDEADBEEF);
    vecs[10] = mk(1, 0, 32'h200, 4'hF, 32'h0,        1, 0, 1, 32'hCAFEF00D, 1, 1, 0, 32'h200, 32'hDEADBEEF);
    vecs[11] = mk(1, 0, 32'h200, 4'hF, 32'h0,        1, 0, 0, 32'h0,        0, 0, 0, 32'h200, 32'hCAFEF00D);
    vecs[12] = mk(1, 0, 32'h200, 4'hF, 32'h0,        1, 0, 1, 32'hBAADBAAD, 0, 0, 0, 32'h200, 32'hCAFEF00D);
    vecs[13] = mk(1, 0, 32'h200, 4'hF, 32'h0,        1, 0, 0, 32'h0,        0, 0, 0, 32'h200, 32'hCAFEF00D);
    vecs[14] = mk(1, 0, 32'h200, 4'hF, 32'h0,        1, 0, 0, 32'h0,        0, 0, 0, 32'h200, 32'hCAFEF00D);
    vecs[15] = mk(1, 0, 32'h200, 4'hF, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 32'h200, 32'hCAFEF00D);
    vecs[16] = mk(0, 0, 32'h0,   4'h0, 32'h0,        0, 0, 1, 32'hBAADBAAD, 0, 0, 0, 32'h200, 32'hCAFEF00D);
    vecs[17] = mk(0, 0, 32'h0,   4'h0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 32'h200, 32'hCAFEF00D);

    // Reset
    rst = 1'b0;
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
    @(posedge clk);
    sample();
    chk("reset_stallreq", {31'b0, stallreq_o}, 32'h0);
    chk("reset_req",      {31'b0, bus_req_o},  32'h0);
    chk("reset_we",       {31'b0, bus_we_o},   32'h0);
    chk("reset_addr",     bus_addr_o,          32'h0);
    chk("reset_sel",      {28'b0, bus_sel_o},  32'h0);
    chk("reset_wdata",    bus_wdata_o,         32'h0);
    chk("reset_data",     cpu_data_o,          32'h0);
    chk("reset_err",      {31'b0, bus_err_o},  32'h0);
    $display("reset applied");
    next_cycle();
    rst = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wdata,
            vecs[i].stall4, vecs[i].flush, vecs[i].ack, vecs[i].rdata);
      sample();
      chk($sformatf("v%0d_stallreq", i), {31'b0, stallreq_o}, {31'b0, vecs[i].exp_sr});
      chk($sformatf("v%0d_req", i),      {31'b0, bus_req_o},  {31'b0, vecs[i].exp_req});
      chk($sformatf("v%0d_we", i),       {31'b0, bus_we_o},   {31'b0, vecs[i].exp_we});
      chk($sformatf("v%0d_addr", i),     bus_addr_o,          vecs[i].exp_addr);
      chk($sformatf("v%0d_data", i),     cpu_data_o,          vecs[i].exp_data);
      chk($sformatf("v%0d_err", i),      {31'b0, bus_err_o},  32'h0);
      if (i == 6) begin
        chk("sb_sel",   {28'b0, bus_sel_o}, 32'h1);
        chk("sb_wdata", bus_wdata_o,        32'h55555555);
      end
      $display("vec %0d: ce=%b we=%b ack=%b st4=%b -> stallreq=%b req=%b addr=%h data=%h",
               i, vecs[i].ce, vecs[i].we, vecs[i].ack, vecs[i].stall4,
               stallreq_o, bus_req_o, bus_addr_o, cpu_data_o);
      next_cycle();
    end

    // Flush in the second BUSY cycle, ack five cycles after the request
    drive(1, 0, 32'h300, 4'hF, 32'h0, 0, 0, 0, 32'h0);
    sample();
    chk("fl_idle_stallreq", {31'b0, stallreq_o}, 32'h1);
    next_cycle();
    sample();
    chk("fl_busy1_req", {31'b0, bus_req_o}, 32'h1);
    chk("fl_busy1_addr", bus_addr_o, 32'h300);
    next_cycle();
    drive(1, 0, 32'h300, 4'hF, 32'h0, 1, 1, 0, 32'h0);
    sample();
    chk("fl_busy2_req", {31'b0, bus_req_o}, 32'h1);
    chk("fl_busy2_stallreq", {31'b0, stallreq_o}, 32'h1);
    next_cycle();
    drive(0, 0, 32'hFFFF0000, 4'h3, 32'h0, 0, 0, 0, 32'h0);
    sample();
    chk("fl_busy3_req", {31'b0, bus_req_o}, 32'h1);
    chk("fl_busy3_addr_stable", bus_addr_o, 32'h300);
    next_cycle();
    sample();
    chk("fl_busy4_req", {31'b0, bus_req_o}, 32'h1);
    next_cycle();
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 1, 32'h11111111);
    sample();
    chk("fl_busy5_req", {31'b0, bus_req_o}, 32'h1);
    next_cycle();
    // Must be IDLE: a fresh request is immediately seen as a stall
    drive(1, 0, 32'h400, 4'hF, 32'h0, 0, 0, 0, 32'h0);
    sample();
    chk("fl_after_idle_stallreq", {31'b0, stallreq_o}, 32'h1);
    chk("fl_after_req_low", {31'b0, bus_req_o}, 32'h0);
    chk("fl_after_data", cpu_data_o, 32'h11111111);
    next_cycle();
    drive(1, 0, 32'h400, 4'hF, 32'h0, 0, 0, 1, 32'h22222222);
    sample();
    chk("fl_next_req", {31'b0, bus_req_o}, 32'h1);
    chk("fl_next_addr", bus_addr_o, 32'h400);
    next_cycle();
    drive(1, 0, 32'h400, 4'hF, 32'h0, 0, 0, 0, 32'h0);
    sample();
    chk("fl_next_done_stallreq", {31'b0, stallreq_o}, 32'h0);
    chk("fl_next_data", cpu_data_o, 32'h22222222);
    $display("flush sequence: data=%h", cpu_data_o);
    next_cycle();
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
    next_cycle();

    // Asynchronous reset during BUSY
    drive(1, 0, 32'h500, 4'hF, 32'h0, 0, 0, 0, 32'h0);
    next_cycle();
    sample();
    chk("rst_busy_req", {31'b0, bus_req_o}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_req", {31'b0, bus_req_o}, 32'h0);
    chk("rst_async_stallreq", {31'b0, stallreq_o}, 32'h0);
    chk("rst_async_addr", bus_addr_o, 32'h0);
    chk("rst_async_data", cpu_data_o, 32'h0);
    next_cycle();
    rst = 1'b1;
    drive(1, 0, 32'h600, 4'hF, 32'h0, 0, 0, 0, 32'h0);
    sample();
    chk("rst_after_stallreq", {31'b0, stallreq_o}, 32'h1);
    chk("rst_after_req", {31'b0, bus_req_o}, 32'h0);
    next_cycle();
    drive(1, 0, 32'h600, 4'hF, 32'h0, 0, 0, 1, 32'h33333333);
    sample();
    chk("rst_lw_req", {31'b0, bus_req_o}, 32'h1);
    chk("rst_lw_addr", bus_addr_o, 32'h600);
    next_cycle();
    drive(1, 0, 32'h600, 4'hF, 32'h0, 0, 0, 0, 32'h0);
    sample();
    chk("rst_lw_data", cpu_data_o, 32'h33333333);
    chk("rst_lw_stallreq", {31'b0, stallreq_o}, 32'h0);
    $display("reset sequence: data=%h", cpu_data_o);
    next_cycle();
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
    next_cycle();

    // No ack: watchdog when enabled, indefinite wait otherwise
    drive(1, 0, 32'h700, 4'hF, 32'h0, 0, 0, 0, 32'h0);
    next_cycle();
`ifdef DBUS_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      sample();
      chk($sformatf("to_busy%0d_req", k), {31'b0, bus_req_o}, 32'h1);
      chk($sformatf("to_busy%0d_err", k), {31'b0, bus_err_o}, 32'h0);
      next_cycle();
    end
    drive(1, 0, 32'h700, 4'hF, 32'h0, 0, 0, 1, 32'h44444444);
    sample();
    chk("to_err_pulse", {31'b0, bus_err_o}, 32'h1);
    chk("to_req_low", {31'b0, bus_req_o}, 32'h0);
    chk("to_data_zero", cpu_data_o, 32'h0);
    chk("to_stallreq", {31'b0, stallreq_o}, 32'h0);
    next_cycle();
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
    sample();
    chk("to_err_cleared", {31'b0, bus_err_o}, 32'h0);
    chk("to_late_ack_ignored", cpu_data_o, 32'h0);
    $display("timeout sequence: err=%b data=%h", bus_err_o, cpu_data_o);
`else
    for (int k = 1; k <= 20; k++) begin
      sample();
      chk($sformatf("wait%0d_req", k), {31'b0, bus_req_o}, 32'h1);
      chk($sformatf("wait%0d_stallreq", k), {31'b0, stallreq_o}, 32'h1);
      chk($sformatf("wait%0d_err", k), {31'b0, bus_err_o}, 32'h0);
      next_cycle();
    end
    drive(1, 0, 32'h700, 4'hF, 32'h0, 0, 0, 1, 32'h44444444);
    next_cycle();
    drive(1, 0, 32'h700, 4'hF, 32'h0, 0, 0, 0, 32'h0);
    sample();
    chk("wait_done_data", cpu_data_o, 32'h44444444);
    chk("wait_done_req", {31'b0, bus_req_o}, 32'h0);
    chk("wait_done_err", {31'b0, bus_err_o}, 32'h0);
    $display("long wait sequence: data=%h", cpu_data_o);
`endif
    next_cycle();
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
